obstacle_scheduler: RTL

//  Game-level sequencer for the scrolling obstacle datapath. Owns the game FSM, the scroll-step prescaler,

---
 rtl/vga_pkg.sv | 21 ++
 rtl/game_lfsr16.sv | 14 +
 rtl/obstacle_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and default geometry for the scrolling-obstacle game datapath.
package vga_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_RUN  = 2'd1,
    GS_OVER = 2'd2
  } game_state_t;

  localparam int unsigned COORD_W       = 12;
  localparam int unsigned SCORE_W       = 16;
  localparam int unsigned PLAYER_X_DEF  = 100;
  localparam int unsigned PLAYER_W_DEF  = 40;
  localparam int unsigned PLAYER_H_DEF  = 40;
  localparam int unsigned OBST_W_DEF    = 60;
  localparam int unsigned GAP_Y_MIN_DEF = 100;
  localparam int unsigned GAP_H_DEF     = 150;
  localparam int unsigned FLOOR_Y_DEF   = 560;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;

endpackage

// File: rtl/game_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), loaded with seed on reset.
module game_lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= seed;
    else     q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Game sequencer: FSM, scroll prescaler, obstacle spawn/retire, collision and score.
module obstacle_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned N_OBST    = 2,
  parameter int unsigned CLK_DIV   = 400_000,
  parameter int unsigned SPAWN_X   = 750,
  parameter int unsigned SPACING   = 400,
  parameter int unsigned OBST_W    = OBST_W_DEF,
  parameter int unsigned GAP_Y_MIN = GAP_Y_MIN_DEF,
  parameter int unsigned GAP_H     = GAP_H_DEF,
  parameter int unsigned PLAYER_X  = PLAYER_X_DEF,
  parameter int unsigned PLAYER_W  = PLAYER_W_DEF,
  parameter int unsigned PLAYER_H  = PLAYER_H_DEF,
  parameter int unsigned FLOOR_Y   = FLOOR_Y_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [COORD_W-1:0]        player_y,
  output logic [N_OBST*COORD_W-1:0] obst_x,
  output logic [N_OBST*COORD_W-1:0] gap_top,
  output logic [N_OBST*COORD_W-1:0] gap_bot,
  output logic [N_OBST-1:0]         obst_valid,
  output logic [1:0]                game_state,
  output logic                      endgame,
  output logic [SCORE_W-1:0]        score
);

  localparam int unsigned PS_W  = $clog2(CLK_DIV);
  localparam int unsigned SPC_W = $clog2(SPACING + 1);
  localparam int unsigned SUM_W = COORD_W + 1;

  game_state_t state_q, state_d;
  logic [PS_W-1:0]    ps_q;
  logic [SPC_W-1:0]   spc_q;
  logic [COORD_W-1:0] x_q   [N_OBST];
  logic [COORD_W-1:0] top_q [N_OBST];
  logic [COORD_W-1:0] bot_q [N_OBST];
  logic [N_OBST-1:0]  valid_q;
  logic [SCORE_W-1:0] score_q;
  logic               endgame_q;
  logic [15:0]        lfsr;
  logic               unused_lfsr_hi;

  logic               hit_c, step_c, clear_c, free_c, spawn_due_c;
  logic [N_OBST-1:0]  spawn_sel_c;
  logic [2:0]         retire_cnt_c;
  logic [SCORE_W:0]   score_sum_c;
  logic [SCORE_W-1:0] score_next_c;
  logic [COORD_W-1:0] new_top_c;

  game_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:8];

  // Collision against player rectangle or floor, only while running
  always_comb begin
    hit_c = 1'b0;
    if (state_q == GS_RUN) begin
      if (SUM_W'(player_y) + SUM_W'(PLAYER_H) > SUM_W'(FLOOR_Y)) hit_c = 1'b1;
      for (int unsigned i = 0; i < N_OBST; i++) begin
        if (valid_q[i]
            && SUM_W'(x_q[i]) <= SUM_W'(PLAYER_X + PLAYER_W - 1)
            && SUM_W'(x_q[i]) + SUM_W'(OBST_W - 1) >= SUM_W'(PLAYER_X)
            && (player_y < top_q[i]
                || SUM_W'(player_y) + SUM_W'(PLAYER_H) > SUM_W'(bot_q[i])))
          hit_c = 1'b1;
      end
    end
  end

  // Retire count, saturating score and lowest-free-slot pick
  always_comb begin
    retire_cnt_c = '0;
    free_c       = 1'b0;
    spawn_sel_c  = '0;
    for (int unsigned i = 0; i < N_OBST; i++) begin
      if (valid_q[i] && x_q[i] == '0) retire_cnt_c = retire_cnt_c + 3'd1;
      if (!valid_q[i] && !free_c) begin
        spawn_sel_c[i] = 1'b1;
        free_c         = 1'b1;
      end
    end
    score_sum_c  = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(retire_cnt_c);
    score_next_c = score_sum_c[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_c[SCORE_W-1:0];
  end

  assign step_c      = (state_q == GS_RUN) && (ps_q == PS_W'(CLK_DIV - 1)) && !hit_c;
  assign clear_c     = start && (state_q == GS_IDLE || state_q == GS_OVER);
  assign spawn_due_c = spc_q >= SPC_W'(SPACING);
  assign new_top_c   = COORD_W'(GAP_Y_MIN) + COORD_W'(lfsr[7:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      GS_IDLE: if (start) state_d = GS_RUN;
      GS_RUN:  if (hit_c) state_d = GS_OVER;
      GS_OVER: if (start) state_d = GS_IDLE;
      default: state_d = GS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GS_IDLE;
      endgame_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      endgame_q <= (state_d == GS_OVER);
    end
  end

  // Slot datapath; a hit in the step cycle suppresses the whole step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q    <= '0;
      spc_q   <= '0;
      score_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < N_OBST; i++) begin
        x_q[i]   <= '0;
        top_q[i] <= '0;
        bot_q[i] <= '0;
      end
    end else begin
      if (clear_c) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < N_OBST; i++) begin
          x_q[i]   <= '0;
          top_q[i] <= '0;
          bot_q[i] <= '0;
        end
      end
      if (start && state_q == GS_IDLE) begin
        score_q <= '0;
        ps_q    <= '0;
        spc_q   <= SPC_W'(SPACING);
      end else if (state_q == GS_RUN) begin
        ps_q <= (ps_q == PS_W'(CLK_DIV - 1)) ? '0 : PS_W'(ps_q + 1'b1);
        if (step_c) begin
          score_q <= score_next_c;
          for (int unsigned i = 0; i < N_OBST; i++) begin
            if (valid_q[i]) begin
              if (x_q[i] == '0) valid_q[i] <= 1'b0;
              else              x_q[i]     <= x_q[i] - 1'b1;
            end
          end
          if (spawn_due_c) begin
            if (free_c) begin
              spc_q <= '0;
              for (int unsigned i = 0; i < N_OBST; i++) begin
                if (spawn_sel_c[i]) begin
                  x_q[i]     <= COORD_W'(SPAWN_X);
                  top_q[i]   <= new_top_c;
                  bot_q[i]   <= new_top_c + COORD_W'(GAP_H);
                  valid_q[i] <= 1'b1;
                end
              end
            end else begin
              spc_q <= SPC_W'(SPACING);
            end
          end else begin
            spc_q <= SPC_W'(spc_q + 1'b1);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N_OBST; g++) begin : g_flat
    assign obst_x [COORD_W*g +: COORD_W] = x_q[g];
    assign gap_top[COORD_W*g +: COORD_W] = top_q[g];
    assign gap_bot[COORD_W*g +: COORD_W] = bot_q[g];
  end

  assign obst_valid = valid_q;
  assign game_state = state_q;
  assign endgame    = endgame_q;
  assign score      = score_q;

endmodule
